// File: rtl/fetch_controller.sv
// Purpose  : Owns the PC and sequences an asynchronous instruction memory into a one-entry IF/ID register.
// Latency  : the address is held WAIT_CYCLES+1 cycles before the word is captured; the first if_valid appears WAIT_CYCLES+1 edges after reset.
// Backpress: stall holds the IF/ID entry, and fetch waits with pc and cnt frozen; a redirect overrides stall.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   imem_addr           word address to instruction memory (the pc register)
//   imem_data           instruction memory read data
//   stall               hazard unit request to hold the IF/ID register
//   redirect_valid/_pc  taken branch/jump and its target
//   if_instr/if_pc      fetched instruction and its address
//   if_valid            if_instr/if_pc valid; consumed on any edge where stall is low
//   halted              fetch stopped on HALT_WORD; only a redirect or reset clears it
//   instr_count         instructions delivered (16-bit, wraps)
module fetch_controller #(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 32,
  parameter int                 WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD   = 32'h1234abcd
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              halted,
  output logic [15:0]       instr_count
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       count_q, count_d;
  logic              slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // The slot is busy only when an undelivered entry is being held by stall.
  assign slot_free = !(valid_q && stall);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    count_d = count_q;

    // The entry is consumed on any unstalled edge; a capture below refills it.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Any capture this cycle belongs to the wrong path and is dropped.
      state_d = ST_FETCH;
      pc_d    = redirect_pc;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (cnt_q != WAIT_CNT) begin
            cnt_d = cnt_q + 4'd1;
          end else if (slot_free) begin
            if (imem_data != HALT_WORD) begin
              instr_d = imem_data;
              if_pc_d = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + ADDR_W'(1);
              cnt_d   = '0;
              count_d = count_q + 16'd1;
            end else begin
              // The unmapped-address word is never delivered; pc stays on it.
              state_d = ST_HALTED;
            end
          end
          // When the slot is busy, pc and cnt hold and the capture is retried.
        end
        ST_HALTED: begin
          // No captures; only a redirect or reset leaves this state.
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = if_pc_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == ST_HALTED);
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam logic [31:0] HALT = 32'h1234abcd;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [15:0] instr_count;
  logic        full_map;

  int total = 0;
  int bad   = 0;

  fetch_controller #(
    .ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(1),
    .RESET_PC(16'h0000), .HALT_WORD(32'h1234abcd)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prog(input logic [15:0] a);
    case (a)
      16'd0:   prog = 32'h8CE10010;
      16'd1:   prog = 32'h00A53020;
      16'd2:   prog = 32'hAC620004;
      16'd3:   prog = 32'h10A0FFFE;
      16'd4:   prog = 32'h20420001;
      16'd5:   prog = 32'h08000000;
      default: prog = HALT;
    endcase
  endfunction

  // Asynchronous memory: either the 6-word program or a map that covers every address.
  always_comb begin
    imem_data = full_map ? {16'hC0DE, imem_addr} : prog(imem_addr);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; full_map = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'h0 || if_pc !== 16'h0) begin bad++; $display("FAIL reset_ifreg got=%h/%h exp=0/0", if_instr, if_pc); end
    total++; if (halted !== 1'b0 || instr_count !== 16'h0) begin bad++; $display("FAIL reset_halt_cnt got=%b/%0d exp=0/0", halted, instr_count); end
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (if_valid !== ((e % 2) == 0)) begin bad++; $display("FAIL seq_valid edge=%0d got=%b exp=%b", e, if_valid, (e % 2) == 0); end
      if ((e % 2) == 0) begin
        total++;
        if (if_pc !== 16'(e / 2 - 1) || if_instr !== prog(16'(e / 2 - 1)) || instr_count !== 16'(e / 2)) begin
          bad++;
          $display("FAIL seq_data edge=%0d got=%h/%h/%0d exp=%h/%h/%0d", e, if_pc, if_instr, instr_count,
                   16'(e / 2 - 1), prog(16'(e / 2 - 1)), e / 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    // Entry pc=2 is valid; pc register is 3.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 16'd2 || if_instr !== prog(16'd2) || imem_addr !== 16'd3) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%h/%h exp=1/0002/%h/0003", i, if_valid, if_pc, if_instr, imem_addr, prog(16'd2));
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'd3 || instr_count !== 16'd4) begin
      bad++; $display("FAIL stall_resume got=%b/%h/%0d exp=1/0003/4", if_valid, if_pc, instr_count);
    end
  endtask

  task automatic test_redirect();
    // A: redirect on a capture edge while stalled with a valid entry.
    stall = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0004;
    tick();
    total++;
    if (if_valid !== 1'b0 || instr_count !== 16'd4 || imem_addr !== 16'h0004) begin
      bad++; $display("FAIL redir_stall got=%b/%0d/%h exp=0/4/0004", if_valid, instr_count, imem_addr);
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0004 || if_instr !== prog(16'd4) || instr_count !== 16'd5) begin
      bad++; $display("FAIL redir_next got=%b/%h/%0d exp=1/0004/5", if_valid, if_pc, instr_count);
    end
    // B: redirect on an edge where word 5 would otherwise be captured.
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    total++;
    if (if_valid !== 1'b0 || instr_count !== 16'd5 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL redir_discard got=%b/%0d/%h exp=0/5/0000", if_valid, instr_count, imem_addr);
    end
    redirect_valid = 1'b0;
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 32'h8CE10010 || instr_count !== 16'd6) begin
      bad++; $display("FAIL redir_restart got=%b/%h/%h/%0d exp=1/0000/8ce10010/6", if_valid, if_pc, if_instr, instr_count);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 40 && halted !== 1'b1; i++) tick();
    total++;
    if (halted !== 1'b1 || imem_addr !== 16'h0006 || instr_count !== 16'd11 || if_valid !== 1'b0) begin
      bad++; $display("FAIL halt_enter got=%b/%h/%0d/%b exp=1/0006/11/0", halted, imem_addr, instr_count, if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (halted !== 1'b1 || imem_addr !== 16'h0006 || if_valid !== 1'b0 || instr_count !== 16'd11) begin
        bad++; $display("FAIL halt_hold cyc=%0d got=%b/%h/%b/%0d exp=1/0006/0/11", i, halted, imem_addr, if_valid, instr_count);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (halted !== 1'b0 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL halt_exit got=%b/%h exp=0/0000", halted, imem_addr);
    end
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || instr_count !== 16'd12) begin
      bad++; $display("FAIL halt_resume got=%b/%h/%0d exp=1/0000/12", if_valid, if_pc, instr_count);
    end
  endtask

  task automatic test_wrap();
    full_map = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'hFFFF || if_instr !== 32'hC0DEFFFF || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL wrap_ffff got=%b/%h/%h/%h exp=1/ffff/c0deffff/0000", if_valid, if_pc, if_instr, imem_addr);
    end
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 32'hC0DE0000 || instr_count !== 16'd14) begin
      bad++; $display("FAIL wrap_0000 got=%b/%h/%h/%0d exp=1/0000/c0de0000/14", if_valid, if_pc, if_instr, instr_count);
    end
  endtask

  task automatic test_async_reset();
    // Mid-wait with an entry valid; reset lands between edges.
    #2 reset = 1'b1;
    #1;
    total++;
    if (if_valid !== 1'b0 || if_pc !== 16'h0 || if_instr !== 32'h0 || imem_addr !== 16'h0 ||
        halted !== 1'b0 || instr_count !== 16'h0) begin
      bad++; $display("FAIL async_reset got=%b/%h/%h/%h/%b/%0d exp=0/0000/00000000/0000/0/0",
                      if_valid, if_pc, if_instr, imem_addr, halted, instr_count);
    end
    full_map = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    total++;
    if (if_valid !== 1'b0) begin bad++; $display("FAIL post_reset_wait got=%b exp=0", if_valid); end
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 32'h8CE10010 || instr_count !== 16'd1) begin
      bad++; $display("FAIL post_reset_first got=%b/%h/%h/%0d exp=1/0000/8ce10010/1", if_valid, if_pc, if_instr, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
